// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - shared CP0 exception sequencer types and constants
// Purpose: FSM state encoding, ExcCode values, CP0 register indices and
//          Status bit positions shared by the exception sequencer files.
package cp0_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_SAVE,
    S_VECTOR,
    S_ERET
  } exc_state_e;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;

  localparam int CP0_STATUS = 12;
  localparam int CP0_CAUSE  = 13;
  localparam int CP0_EPC    = 14;

  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;

endpackage

// File: rtl/cp0_exc_ctrl_if.sv
// rtl/cp0_exc_ctrl_if.sv - pipeline/CP0 side bundle of the exception sequencer
// Purpose: groups the request, status and strobe signals between the ID/WB
//          control, the CP0 file and the exception sequencer.
// Modports: slave  - the sequencer (requests/status in, strobes out)
//           master - the pipeline/CP0 environment (the opposite directions)
interface cp0_exc_ctrl_if #(
  parameter int NUM_IRQ = 6
);
  import cp0_pkg::*;

  logic [NUM_IRQ-1:0] irq;
  logic               syscall_req;
  logic [29:0]        syscall_pc;
  logic               eret_req;
  logic [29:0]        resume_pc;
  logic               pipe_empty;
  logic               status_ie;
  logic               status_exl;
  logic [NUM_IRQ-1:0] status_im;
  logic [31:0]        epc_in;

  logic               stall;
  logic               flush;
  logic               epc_we;
  logic [31:0]        epc_wdata;
  logic               cause_we;
  logic [4:0]         cause_exc;
  logic [NUM_IRQ-1:0] cause_ip;
  logic               exl_set;
  logic               exl_clr;
  logic               redir_valid;
  logic [31:0]        redir_pc;
  logic               busy;

  modport slave (
    input  irq, syscall_req, syscall_pc, eret_req, resume_pc, pipe_empty,
           status_ie, status_exl, status_im, epc_in,
    output stall, flush, epc_we, epc_wdata, cause_we, cause_exc, cause_ip,
           exl_set, exl_clr, redir_valid, redir_pc, busy
  );

  modport master (
    output irq, syscall_req, syscall_pc, eret_req, resume_pc, pipe_empty,
           status_ie, status_exl, status_im, epc_in,
    input  stall, flush, epc_we, epc_wdata, cause_we, cause_exc, cause_ip,
           exl_set, exl_clr, redir_valid, redir_pc, busy
  );

endinterface

// File: rtl/cp0_exc_ctrl_irq_sync.sv
// rtl/cp0_exc_ctrl_irq_sync.sv - two-flop synchronizer for external IRQ lines
// Purpose: brings asynchronous interrupt requests into the clk domain.
// Ports: clk, rst (async, active-high), d_i raw lines, q_o synchronized lines.
module irq_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// rtl/cp0_exc_ctrl.sv - CP0 exception/interrupt sequencer
// Purpose: arbitrates syscall > ERET > interrupt, stalls and drains the
//          pipeline, issues EPC/Cause/Status.EXL write strobes and redirects
//          fetch to VECTOR_PC or back to EPC.
// Ports: clk, rst (async, active-high); bus (cp0_exc_ctrl_if.slave) carries
//        requests, Status fields, epc_in and all strobe/redirect outputs.
// Option: CP0_IRQ_SYNC_EN inserts a 2-flop synchronizer ahead of the
//         pending-IRQ latch (adds 2 cycles of interrupt latency).
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter int          NUM_IRQ   = 6,
  parameter logic [31:0] VECTOR_PC = 32'h0000_4180,
  parameter int          DRAIN_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  cp0_exc_ctrl_if.slave bus
);

  localparam int            CW       = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_MAX - 1);

  exc_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_IRQ-1:0] pend_q, irq_src;
  logic               int_ok;

  logic               stall_q, stall_d, flush_q, flush_d;
  logic               epc_we_q, epc_we_d, cause_we_q, cause_we_d;
  logic               exl_set_q, exl_set_d, exl_clr_q, exl_clr_d;
  logic               redir_valid_q, redir_valid_d;
  logic [31:0]        epc_wdata_q, epc_wdata_d, redir_pc_q, redir_pc_d;
  logic [4:0]         cause_exc_q, cause_exc_d;
  logic [NUM_IRQ-1:0] cause_ip_q, cause_ip_d;

`ifdef CP0_IRQ_SYNC_EN
  irq_sync #(.W(NUM_IRQ)) u_irq_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.irq),
    .q_o (irq_src)
  );
`else
  assign irq_src = bus.irq;
`endif

  assign int_ok = (|(pend_q & bus.status_im)) & bus.status_ie & ~bus.status_exl;

  // Outputs are computed for the state being entered and registered, so every
  // strobe is a clean flop output aligned with its state.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    epc_wdata_d   = epc_wdata_q;
    cause_exc_d   = cause_exc_q;
    cause_ip_d    = cause_ip_q;
    redir_pc_d    = redir_pc_q;
    stall_d       = 1'b0;
    flush_d       = 1'b0;
    epc_we_d      = 1'b0;
    cause_we_d    = 1'b0;
    exl_set_d     = 1'b0;
    exl_clr_d     = 1'b0;
    redir_valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.syscall_req || (!bus.eret_req && int_ok)) begin
          state_d     = S_DRAIN;
          cnt_d       = '0;
          cause_exc_d = bus.syscall_req ? EXC_SYS : EXC_INT;
          cause_ip_d  = pend_q & bus.status_im;
          stall_d     = 1'b1;
        end else if (bus.eret_req) begin
          state_d       = S_ERET;
          redir_valid_d = 1'b1;
          redir_pc_d    = bus.epc_in;
          exl_clr_d     = 1'b1;
          flush_d       = 1'b1;
        end
      end
      S_DRAIN: begin
        stall_d = 1'b1;
        if (bus.pipe_empty || cnt_q == CNT_LAST) begin
          state_d     = S_SAVE;
          epc_wdata_d = {(cause_exc_q == EXC_SYS) ? bus.syscall_pc : bus.resume_pc, 2'b00};
          epc_we_d    = 1'b1;
          cause_we_d  = 1'b1;
          exl_set_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SAVE: begin
        state_d       = S_VECTOR;
        redir_valid_d = 1'b1;
        redir_pc_d    = VECTOR_PC;
        flush_d       = 1'b1;
      end
      S_VECTOR, S_ERET: state_d = S_IDLE;
      default:          state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      pend_q        <= '0;
      stall_q       <= 1'b0;
      flush_q       <= 1'b0;
      epc_we_q      <= 1'b0;
      cause_we_q    <= 1'b0;
      exl_set_q     <= 1'b0;
      exl_clr_q     <= 1'b0;
      redir_valid_q <= 1'b0;
      epc_wdata_q   <= '0;
      redir_pc_q    <= '0;
      cause_exc_q   <= '0;
      cause_ip_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pend_q        <= irq_src;
      stall_q       <= stall_d;
      flush_q       <= flush_d;
      epc_we_q      <= epc_we_d;
      cause_we_q    <= cause_we_d;
      exl_set_q     <= exl_set_d;
      exl_clr_q     <= exl_clr_d;
      redir_valid_q <= redir_valid_d;
      epc_wdata_q   <= epc_wdata_d;
      redir_pc_q    <= redir_pc_d;
      cause_exc_q   <= cause_exc_d;
      cause_ip_q    <= cause_ip_d;
    end
  end

  assign bus.stall       = stall_q;
  assign bus.flush       = flush_q;
  assign bus.epc_we      = epc_we_q;
  assign bus.epc_wdata   = epc_wdata_q;
  assign bus.cause_we    = cause_we_q;
  assign bus.cause_exc   = cause_exc_q;
  assign bus.cause_ip    = cause_ip_q;
  assign bus.exl_set     = exl_set_q;
  assign bus.exl_clr     = exl_clr_q;
  assign bus.redir_valid = redir_valid_q;
  assign bus.redir_pc    = redir_pc_q;
  assign bus.busy        = (state_q != S_IDLE);

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
Exception/interrupt sequencer for the coprocessor-0 register file in the 5-stage pipeline.
- Arbitrates syscall, ERET and external interrupt requests.
- Stalls and drains the pipeline, then issues the CP0 write strobes (EPC, Cause, Status.EXL).
- Redirects fetch to the handler vector, or back to EPC on ERET.
- Sits between the ID/WB stage control and the CP0 file; owns no architectural state except a pending-IRQ latch.

Parameters:
NUM_IRQ, 6, number of external interrupt lines; maps to Cause.IP/Status.IM bits [NUM_IRQ+9:10].
VECTOR_PC, 32'h0000_4180, handler entry address.
DRAIN_MAX, 8, maximum drain wait in cycles; after this the drain is forced complete.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
irq  in  NUM_IRQ  level-sensitive external interrupt requests.
syscall_req  in  1  ID stage holds a syscall; held stable while stall=1.
syscall_pc  in  30  word PC of the syscall (PC[31:2]).
eret_req  in  1  ID stage holds an ERET; held stable while stall=1.
resume_pc  in  30  word PC of the oldest unretired instruction (interrupt EPC).
pipe_empty  in  1  EX/MEM/WB hold no valid instruction.
status_ie  in  1  Status[0].
status_exl  in  1  Status[1].
status_im  in  NUM_IRQ  Status interrupt mask.
epc_in  in  32  current CP0[14].
stall  out  1  freeze IF/ID.
flush  out  1  kill IF/ID contents; one cycle.
epc_we  out  1  write CP0[14]; one cycle.
epc_wdata  out  32  {pc,2'b00}.
cause_we  out  1  write Cause.ExcCode (bits [6:2]) and Cause.IP.
cause_exc  out  5  0 = Int, 8 = Sys.
cause_ip  out  NUM_IRQ  snapshot of the pending IRQs.
exl_set  out  1  set Status[1]; one cycle.
exl_clr  out  1  clear Status[1]; one cycle.
redir_valid  out  1  PC mux override; one cycle.
redir_pc  out  32  target PC.
busy  out  1  FSM not in IDLE.

Behaviour:
- Reset: FSM goes to IDLE; the pending latch, drain counter and all outputs are 0.
- Pending latch: pend <= irq every cycle (irq_s when the optional feature is on).
- Interrupt eligibility: int_ok = |(pend & status_im) & status_ie & ~status_exl.
- Arbitration in IDLE, fixed priority: syscall_req > eret_req > int_ok. Requests are ignored outside IDLE.
- States: IDLE, DRAIN, SAVE, VECTOR, ERET.
- IDLE -> DRAIN on syscall or int_ok.
  - Latch kind (SYS/INT) and cause_ip = pend & status_im; drain counter = 0.
  - stall = 1 from the first DRAIN cycle.
- DRAIN: stall = 1; counter increments each cycle.
  - Exit to SAVE when pipe_empty = 1 or counter == DRAIN_MAX-1.
  - On exit, latch the EPC source: syscall_pc for SYS, resume_pc for INT.
- SAVE: one cycle; stall = 1.
  - epc_we = cause_we = exl_set = 1.
  - cause_exc = 8 for SYS, 0 for INT.
- VECTOR: one cycle; redir_valid = 1, redir_pc = VECTOR_PC, flush = 1, stall = 0. Then IDLE.
- IDLE -> ERET on eret_req when no syscall is present.
  - ERET state, one cycle: redir_valid = 1, redir_pc = epc_in, exl_clr = 1, flush = 1. Then IDLE.
  - ERET with status_exl = 0 behaves identically; no error is raised.
- Latency:
  - Syscall with pipe_empty already 1: request seen at cycle 0 → SAVE strobes at cycle 2 → redirect at cycle 3.
  - ERET: redirect at cycle 1.
- IRQ deasserting during DRAIN: the exception still completes with the snapshotted cause_ip.
- Back-to-back requests: no new interrupt is taken while status_exl = 1. The EXL set in SAVE masks interrupts, provided the CP0 file updates before the next IDLE.
- Asynchronous reset mid-sequence: abort immediately; no partial strobes after reset deasserts.
- All single-cycle strobes are registered outputs (Moore), glitch-free.

Optional Feature:
Macro CP0_IRQ_SYNC_EN.
- Defined: each irq bit passes through a 2-flop synchronizer (reset 0) before the pending latch. Interrupt recognition latency grows by 2 cycles.
- Undefined: irq is sampled directly; irq must be synchronous to clk.

Decomposition:
- Shared package cp0_pkg: FSM state enum, ExcCode constants (EXC_INT=5'd0, EXC_SYS=5'd8), CP0 register indices (CP0_STATUS=12, CP0_CAUSE=13, CP0_EPC=14), Status bit positions (ST_IE=0, ST_EXL=1).
- One sub-module, irq_sync: the parameterised 2-flop synchronizer used under CP0_IRQ_SYNC_EN.

Test Plan:
- Syscall: syscall_req=1, syscall_pc=30'h0000_0041, pipe_empty=1 → SAVE cycle has epc_wdata=32'h104, cause_exc=8, exl_set=1; next cycle redir_pc=32'h4180 with flush.
- Interrupt: irq=6'b000100, status_im=6'b000100, ie=1, exl=0, pipe_empty delayed 3 cycles → stall held 3+ cycles, cause_ip=6'b000100, cause_exc=0, epc=resume_pc sampled at DRAIN exit.
- Masking: irq=6'b000001 with status_im=0, or with exl=1 → busy stays 0 and no strobes for 20 cycles.
- Priority: syscall_req, eret_req and int_ok all asserted in the same cycle → SYS path taken; ERET is serviced only after return to IDLE.
- ERET: eret_req=1, epc_in=32'h0000_0108 → next cycle redir_pc=32'h108, exl_clr=1, flush=1.
- Drain timeout and reset: pipe_empty held 0 → SAVE after DRAIN_MAX cycles. Separately, rst pulsed during DRAIN → all outputs 0, FSM in IDLE, no epc_we afterward.
